// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
//   op_e    : operation codes carried on the 'op' port of mips_muldiv
//   state_e : sequencer states (IDLE -> RUN -> FIX -> IDLE)
//   op_is_signed / op_is_div : classification helpers for an op code
package mips_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mips_divstep.sv
// One iteration of unsigned restoring division (purely combinational).
//   rem_in  : partial remainder entering the step
//   quo_in  : dividend bits still to be consumed (MSB first); quotient
//             bits are shifted in at the LSB end as they are produced
//   divisor : unsigned divisor
//   rem_out : partial remainder after the step
//   quo_out : quo_in shifted left by one with the new quotient bit appended
module mips_divstep #(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] rem_in,
    input  logic [WORD_SIZE-1:0] quo_in,
    input  logic [WORD_SIZE-1:0] divisor,
    output logic [WORD_SIZE-1:0] rem_out,
    output logic [WORD_SIZE-1:0] quo_out
);

    logic [WORD_SIZE:0]   shifted;
    logic                 fits;
    logic [WORD_SIZE-1:0] diff;

    // Bring the next dividend bit into the remainder. The shifted value is
    // one bit wider; when the divisor fits, the difference is always below
    // the divisor, so only the low WORD_SIZE bits of the subtraction matter.
    assign shifted = {rem_in, quo_in[WORD_SIZE-1]};
    assign fits    = shifted >= {1'b0, divisor};
    assign diff    = shifted[WORD_SIZE-1:0] - divisor;

    assign rem_out = fits ? diff : shifted[WORD_SIZE-1:0];
    assign quo_out = {quo_in[WORD_SIZE-2:0], fits};

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit.
// Multiplies by shift-add and divides by restoring subtraction, one bit per
// cycle, on operand magnitudes; signs are reapplied in a final FIX cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   start, op     : request and operation (see mips_pkg::op_e)
//   a, b          : operands (a is also the MTHI/MTLO source)
//   flush         : abort an in-flight operation, HI/LO untouched
//   busy          : operation in flight (WORD_SIZE+1 cycles per mul/div)
//   done, dbz     : result-written pulse, divide-by-zero flag (held)
//   hi, lo        : HI/LO architectural registers
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic                 dbz,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int CNT_W = $clog2(WORD_SIZE);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WORD_SIZE - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] acc_hi_q, acc_hi_d;
    logic [WORD_SIZE-1:0] acc_lo_q, acc_lo_d;
    logic [WORD_SIZE-1:0] opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 a_neg_q, a_neg_d;
    logic                 b_neg_q, b_neg_d;
    logic [WORD_SIZE-1:0] hi_q, hi_d;
    logic [WORD_SIZE-1:0] lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic                 start_signed, start_div;
    logic                 a_neg_in, b_neg_in;
    logic [WORD_SIZE-1:0] a_mag, b_mag;
    logic [WORD_SIZE-1:0] mul_addend;
    logic [WORD_SIZE:0]   mul_sum;
    logic [WORD_SIZE-1:0] div_rem, div_quo;
    logic [2*WORD_SIZE-1:0] prod, prod_fix;
    logic [WORD_SIZE-1:0] quo_fix, rem_fix;
    logic                 div_zero;

    // Operand magnitudes. The most-negative value maps onto itself, which
    // read as unsigned is exactly its magnitude.
    assign start_signed = op_is_signed(op);
    assign start_div    = op_is_div(op);
    assign a_neg_in     = start_signed & a[WORD_SIZE-1];
    assign b_neg_in     = start_signed & b[WORD_SIZE-1];
    assign a_mag        = a_neg_in ? -a : a;
    assign b_mag        = b_neg_in ? -b : b;

    // Multiply keeps the multiplier in acc_lo; each step adds the
    // multiplicand into acc_hi when the multiplier LSB is set and shifts
    // the whole {carry, acc_hi, acc_lo} pair right.
    assign mul_addend = acc_lo_q[0] ? opnd_q : '0;
    assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};

    // Divide keeps the remainder in acc_hi and dividend/quotient in acc_lo.
    mips_divstep #(.WORD_SIZE(WORD_SIZE)) u_divstep (
        .rem_in  (acc_hi_q),
        .quo_in  (acc_lo_q),
        .divisor (opnd_q),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    // A zero divisor makes every step "fit", so the remainder ends up as
    // |a|; restoring the dividend sign then yields hi = a with no special
    // case, and only lo needs forcing to all ones.
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
    assign quo_fix  = (a_neg_q ^ b_neg_q) ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = a_neg_q ? -acc_hi_q : acc_hi_q;
    assign div_zero = (opnd_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        case (state_q)
            ST_IDLE: begin
                // Flush wins over a simultaneous start.
                if (start && !flush) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d = start_div;
                            a_neg_d  = a_neg_in;
                            b_neg_d  = b_neg_in;
                            acc_hi_d = '0;
                            acc_lo_d = start_div ? a_mag : b_mag;
                            opnd_d   = start_div ? b_mag : a_mag;
                            cnt_d    = '0;
                            state_d  = ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = div_rem;
                        acc_lo_d = div_quo;
                    end else begin
                        acc_hi_d = mul_sum[WORD_SIZE:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WORD_SIZE-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        lo_d  = div_zero ? '1 : quo_fix;
                        hi_d  = rem_fix;
                        dbz_d = div_zero;
                    end else begin
                        hi_d  = prod_fix[2*WORD_SIZE-1:WORD_SIZE];
                        lo_d  = prod_fix[WORD_SIZE-1:0];
                        dbz_d = 1'b0;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: a 32-bit and an 8-bit instance,
// directed vectors, random ops against an arithmetic reference model, and
// hand-written timing/priority/reset sequences.
module tb_mips_muldiv;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic        start32, flush32, busy32, done32, dbz32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;

    logic        start8, flush8, busy8, done8, dbz8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    mips_muldiv #(.WORD_SIZE(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
        .flush(flush32), .busy(busy32), .done(done32), .dbz(dbz32),
        .hi(hi32), .lo(lo32)
    );

    mips_muldiv #(.WORD_SIZE(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .busy(busy8), .done(done8), .dbz(dbz8),
        .hi(hi8), .lo(lo8)
    );

    // Reference model: plain 64-bit arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dbz);
        logic [63:0] mask, ua, ub, up;
        longint sa, sb, sp, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & mask;
        ub = {32'd0, b} & mask;
        sa = ua[w-1] ? $signed(ua) - (longint'(1) << w) : $signed(ua);
        sb = ub[w-1] ? $signed(ub) - (longint'(1) << w) : $signed(ub);
        hi = '0; lo = '0; dbz = 1'b0;
        case (op)
            3'd0: begin
                sp = sa * sb;
                up = 64'(sp);
                hi = 32'((up >> w) & mask);
                lo = 32'(up & mask);
            end
            3'd1: begin
                up = ua * ub;
                hi = 32'((up >> w) & mask);
                lo = 32'(up & mask);
            end
            default: begin
                if (ub == 64'd0) begin
                    dbz = 1'b1;
                    lo  = 32'(mask);
                    hi  = 32'(ua);
                end else if (op == 3'd2) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = 32'(64'(q) & mask);
                    hi = 32'(64'(r) & mask);
                end else begin
                    lo = 32'(ua / ub);
                    hi = 32'(ua % ub);
                end
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge: one-cycle start pulse on the 32-bit instance.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic applyStimulus8(input logic [2:0] op, input logic [7:0] a,
                                  input logic [7:0] b);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Counts busy cycles from the first cycle after acceptance.
    task automatic waitDone32(output int cycles);
        cycles = 0;
        while (busy32 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic waitDone8(output int cycles);
        cycles = 0;
        while (busy8 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        logic [2:0]  rop;
        logic [31:0] ra, rb, ehi, elo, st_hi, st_lo;
        logic        edbz, seen;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[2] = '{OP_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1};
        vecs[3] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[6] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8] = '{OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF, 1'b0};
        vecs[9] = '{OP_MULT,  32'h00012345, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFEDCBB, 1'b0};

        rst = 1'b1;
        start32 = 1'b0; flush32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start8  = 1'b0; flush8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset busy", 64'(busy32), 64'd0);
        checkOutput("reset done", 64'(done32), 64'd0);
        checkOutput("reset dbz",  64'(dbz32),  64'd0);
        checkOutput("reset hi",   64'(hi32),   64'd0);
        checkOutput("reset lo",   64'(lo32),   64'd0);

        // Directed table; each op starts in the cycle the previous done is high.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone32(cyc);
            checkOutput($sformatf("vec%0d busy cycles", i), 64'(cyc), 64'd33);
            checkOutput($sformatf("vec%0d done", i), 64'(done32), 64'd1);
            checkOutput($sformatf("vec%0d hi", i), 64'(hi32), 64'(vecs[i].hi));
            checkOutput($sformatf("vec%0d lo", i), 64'(lo32), 64'(vecs[i].lo));
            checkOutput($sformatf("vec%0d dbz", i), 64'(dbz32), 64'(vecs[i].dbz));
        end

        // Random ops, including MTHI/MTLO, against the model.
        st_hi = hi32 === 32'hFFFFFFFF ? 32'hFFFFFFFF : vecs[9].hi;
        st_lo = vecs[9].lo;
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if (rop == OP_MTHI || rop == OP_MTLO) begin
                if (rop == OP_MTHI) st_hi = ra; else st_lo = ra;
                applyStimulus(rop, ra, rb);
                checkOutput($sformatf("rnd%0d mt busy", i), 64'(busy32), 64'd0);
                checkOutput($sformatf("rnd%0d mt hi", i), 64'(hi32), 64'(st_hi));
                checkOutput($sformatf("rnd%0d mt lo", i), 64'(lo32), 64'(st_lo));
            end else begin
                model(32, rop, ra, rb, ehi, elo, edbz);
                st_hi = ehi; st_lo = elo;
                applyStimulus(rop, ra, rb);
                waitDone32(cyc);
                checkOutput($sformatf("rnd%0d op%0d done", i, rop), 64'(done32), 64'd1);
                checkOutput($sformatf("rnd%0d op%0d hi a=%h b=%h", i, rop, ra, rb), 64'(hi32), 64'(ehi));
                checkOutput($sformatf("rnd%0d op%0d lo a=%h b=%h", i, rop, ra, rb), 64'(lo32), 64'(elo));
                checkOutput($sformatf("rnd%0d op%0d dbz", i, rop), 64'(dbz32), 64'(edbz));
            end
        end

        // dbz holds past the done pulse and clears on the next done.
        applyStimulus(OP_DIVU, 32'd9, 32'd0);
        waitDone32(cyc);
        repeat (3) @(negedge clk);
        checkOutput("dbz held", 64'(dbz32), 64'd1);
        checkOutput("done one cycle", 64'(done32), 64'd0);
        applyStimulus(OP_DIVU, 32'd9, 32'd3);
        waitDone32(cyc);
        checkOutput("dbz cleared", 64'(dbz32), 64'd0);
        checkOutput("divu 9/3 lo", 64'(lo32), 64'd3);
        @(negedge clk);

        // MTHI then MTLO on consecutive cycles.
        seen = 1'b0;
        start32 = 1'b1; op32 = OP_MTHI; a32 = 32'h1234;
        @(negedge clk);
        seen |= busy32 | done32;
        op32 = OP_MTLO; a32 = 32'h5678;
        @(negedge clk);
        start32 = 1'b0;
        seen |= busy32 | done32;
        @(negedge clk);
        seen |= busy32 | done32;
        checkOutput("mthi hi", 64'(hi32), 64'h1234);
        checkOutput("mtlo lo", 64'(lo32), 64'h5678);
        checkOutput("mt busy/done seen", 64'(seen), 64'd0);

        // Reserved op codes do nothing.
        for (int c = 6; c < 8; c++) begin
            applyStimulus(3'(c), 32'hFFFF, 32'hFFFF);
            checkOutput($sformatf("reserved op%0d busy", c), 64'(busy32), 64'd0);
            checkOutput($sformatf("reserved op%0d hi/lo", c), {32'(hi32), 32'(lo32)}, 64'h00001234_00005678);
        end

        // Start while busy is ignored; result is the first op's.
        applyStimulus(OP_MULT, 32'd6, 32'd7);
        repeat (2) @(negedge clk);
        applyStimulus(OP_DIVU, 32'd100, 32'd3);
        waitDone32(cyc);
        checkOutput("busy-start done", 64'(done32), 64'd1);
        checkOutput("busy-start hi", 64'(hi32), 64'd0);
        checkOutput("busy-start lo", 64'(lo32), 64'd42);
        @(negedge clk);
        checkOutput("busy-start not queued", 64'(busy32), 64'd0);

        // Flush in RUN cycle 5.
        applyStimulus(OP_DIV, 32'd1000, 32'd7);
        repeat (4) @(negedge clk);
        flush32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        checkOutput("flush run busy", 64'(busy32), 64'd0);
        seen = done32;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen |= done32 | busy32;
        end
        checkOutput("flush run no done", 64'(seen), 64'd0);
        checkOutput("flush run hi/lo", {32'(hi32), 32'(lo32)}, 64'd42);

        // Flush in the FIX cycle.
        applyStimulus(OP_MULT, 32'd3, 32'd5);
        repeat (32) @(negedge clk);
        checkOutput("fix reached busy", 64'(busy32), 64'd1);
        flush32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        checkOutput("flush fix busy", 64'(busy32), 64'd0);
        checkOutput("flush fix done", 64'(done32), 64'd0);
        checkOutput("flush fix hi/lo", {32'(hi32), 32'(lo32)}, 64'd42);

        // Flush together with start in IDLE.
        flush32 = 1'b1;
        applyStimulus(OP_MULT, 32'd3, 32'd3);
        checkOutput("flush+start busy", 64'(busy32), 64'd0);
        applyStimulus(OP_MTHI, 32'hBEEF, 32'd0);
        flush32 = 1'b0;
        checkOutput("flush+mthi hi", 64'(hi32), 64'd0);

        // Asynchronous reset in the middle of a divide.
        applyStimulus(OP_DIVU, 32'd5, 32'd0);
        waitDone32(cyc);
        applyStimulus(OP_DIV, 32'hFFFFFF9C, 32'd3);
        repeat (10) @(negedge clk);
        checkOutput("pre-reset dbz", 64'(dbz32), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst busy", 64'(busy32), 64'd0);
        checkOutput("async rst dbz",  64'(dbz32),  64'd0);
        checkOutput("async rst hi",   64'(hi32),   64'd0);
        checkOutput("async rst lo",   64'(lo32),   64'd0);
        start32 = 1'b1; op32 = OP_MTHI; a32 = 32'd77;
        @(negedge clk);
        start32 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("start during rst hi", 64'(hi32), 64'd0);
        checkOutput("start during rst busy", 64'(busy32), 64'd0);

        // 8-bit instance.
        applyStimulus8(OP_MULTU, 8'hFF, 8'hFF);
        waitDone8(cyc);
        checkOutput("w8 multu cycles", 64'(cyc), 64'd9);
        checkOutput("w8 multu hi", 64'(hi8), 64'hFE);
        checkOutput("w8 multu lo", 64'(lo8), 64'h01);
        applyStimulus8(OP_DIV, 8'h80, 8'hFF);
        waitDone8(cyc);
        checkOutput("w8 div min/-1 lo", 64'(lo8), 64'h80);
        checkOutput("w8 div min/-1 hi", 64'(hi8), 64'h00);
        checkOutput("w8 div min/-1 dbz", 64'(dbz8), 64'd0);
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = 32'($urandom_range(0, 255));
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            model(8, rop, ra, rb, ehi, elo, edbz);
            applyStimulus8(rop, ra[7:0], rb[7:0]);
            waitDone8(cyc);
            checkOutput($sformatf("w8 rnd%0d op%0d hi a=%h b=%h", i, rop, ra[7:0], rb[7:0]), 64'(hi8), 64'(ehi));
            checkOutput($sformatf("w8 rnd%0d op%0d lo a=%h b=%h", i, rop, ra[7:0], rb[7:0]), 64'(lo8), 64'(elo));
            checkOutput($sformatf("w8 rnd%0d dbz", i), 64'(dbz8), 64'(edbz));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
